// File: rtl/seq_tx_pkg.sv
// Shared types and constants for the serial frame transmitter.
package seq_tx_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'b00,
    SHIFT = 2'b01,
    GAP   = 2'b10
  } state_t;

  localparam logic [3:0] DEFAULT_PREAMBLE = 4'b1010;

endpackage

// File: rtl/piso_shift_reg.sv
// Parallel-load, shift-left register exposing its MSB; zeros shift in from the LSB.
module piso_shift_reg #(
  parameter int unsigned WIDTH = 12
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic             shift,
  input  logic [WIDTH-1:0] din,
  output logic             msb
);

  logic [WIDTH-1:0] sr;

  always_ff @(posedge clk) begin
    if (reset) begin
      sr <= '0;
    end else if (load) begin
      sr <= din;
    end else if (shift) begin
      sr <= sr << 1;
    end
  end

  assign msb = sr[WIDTH-1];

endmodule

// File: rtl/seq_frame_tx.sv
// Serial frame transmitter: preamble then payload (both MSB first), then an idle gap.
module seq_frame_tx
  import seq_tx_pkg::*;
#(
  parameter int unsigned      DATA_W     = 8,
  parameter int unsigned      PRE_W      = 4,
  parameter logic [PRE_W-1:0] PREAMBLE   = PRE_W'(DEFAULT_PREAMBLE),
  parameter int unsigned      GAP_CYCLES = 2,
  parameter int unsigned      COUNT_W    = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  data_in,
  input  logic               data_valid,
  output logic               data_ready,
  output logic               out,
  output logic               out_valid,
  output logic               out_is_data,
  output logic               busy,
  output logic               frame_done,
  output logic [COUNT_W-1:0] frame_count
);

  localparam int unsigned FRAME_W = PRE_W + DATA_W;
  localparam int unsigned CNT_W   = $clog2(FRAME_W + 1);
  localparam int unsigned GAP_W   = (GAP_CYCLES > 0) ? $clog2(GAP_CYCLES + 1) : 1;

  state_t             state;
  state_t             state_next;
  logic [CNT_W-1:0]   bit_cnt;
  logic [GAP_W-1:0]   gap_cnt;
  logic               accept;
  logic               last_bit;
  logic               gap_last;
  logic               sr_msb;

  assign accept   = data_valid && (state == IDLE);
  assign last_bit = (state == SHIFT) && (bit_cnt == CNT_W'(FRAME_W - 1));
  // Never true when GAP_CYCLES is 0 because GAP is unreachable then.
  assign gap_last = (state == GAP) && (gap_cnt == GAP_W'(GAP_CYCLES - 1));

  piso_shift_reg #(
    .WIDTH (FRAME_W)
  ) u_piso (
    .clk   (clk),
    .reset (reset),
    .load  (accept),
    .shift (state == SHIFT),
    .din   ({PREAMBLE, data_in}),
    .msb   (sr_msb)
  );

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (data_valid) state_next = SHIFT;
      SHIFT:   if (last_bit) state_next = (GAP_CYCLES == 0) ? IDLE : GAP;
      GAP:     if (gap_last) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      bit_cnt     <= '0;
      gap_cnt     <= '0;
      frame_done  <= 1'b0;
      frame_count <= '0;
    end else begin
      state      <= state_next;
      frame_done <= last_bit;
      if (last_bit) frame_count <= frame_count + COUNT_W'(1);
      if (accept) begin
        bit_cnt <= '0;
      end else if (state == SHIFT) begin
        bit_cnt <= bit_cnt + CNT_W'(1);
      end
      if (state == GAP) begin
        gap_cnt <= gap_cnt + GAP_W'(1);
      end else begin
        gap_cnt <= '0;
      end
    end
  end

  assign data_ready  = (state == IDLE);
  assign busy        = (state != IDLE);
  assign out_valid   = (state == SHIFT);
  assign out         = (state == SHIFT) && sr_msb;
  assign out_is_data = (state == SHIFT) && (bit_cnt >= CNT_W'(PRE_W));

endmodule

// File: doc/seq_frame_tx.md
Name: seq_frame_tx

Overview:
- Serial frame transmitter feeding the single-bit `in` line of the team's serial pattern detectors.
- Accepts a parallel data word via a valid/ready handshake.
- Emits a fixed preamble (default 1010) MSB-first, then the data word MSB-first, then a fixed idle gap.
- Sits upstream of the detector as the sending end of the same serial bit stream; keeps a wrap-around count of completed frames.

Parameters:
- DATA_W, 8, payload width in bits (>=1).
- PRE_W, 4, preamble width in bits (>=1).
- PREAMBLE, 4'b1010, preamble pattern, sent MSB first.
- GAP_CYCLES, 2, idle cycles forced after each frame (>=0).
- COUNT_W, 16, width of frame_count.

Ports:
- clk  input  1  clock, all logic on posedge.
- reset  input  1  reset, synchronous, active-high; clock clk.
- data_in  input  DATA_W  payload word; sampled only on handshake.
- data_valid  input  1  payload offered.
- data_ready  output  1  block can accept payload.
- out  output  1  serial bit stream.
- out_valid  output  1  high while a preamble/data bit is on out.
- out_is_data  output  1  high while a payload bit (not preamble) is on out.
- busy  output  1  high in SHIFT or GAP.
- frame_done  output  1  one-cycle pulse after the last payload bit.
- frame_count  output  COUNT_W  completed frames, wraps to 0.

Behaviour:
- FSM states: IDLE, SHIFT, GAP. Encodings come from the package.
- Reset values: state=IDLE, data_ready=1, out=0, out_valid=0, out_is_data=0, busy=0, frame_done=0, frame_count=0, shift register=0.
- data_ready = (state==IDLE), decoded combinationally from state.
- Handshake fires on a posedge with data_valid && data_ready.
  - On that edge: load shift register {PREAMBLE, data_in} (PRE_W+DATA_W bits), set bit_cnt=0, go to SHIFT.
  - data_valid while not in IDLE is ignored. data_in changes after capture have no effect.
- Latency: the first preamble bit appears on out in the cycle after the accepting edge.
- SHIFT state:
  - out = shift register MSB, out_valid=1.
  - out_is_data=1 when bit_cnt >= PRE_W.
  - Each edge: shift left by one, bit_cnt+1.
  - After PRE_W+DATA_W cycles in SHIFT, go to GAP, or to IDLE if GAP_CYCLES=0.
- Leaving SHIFT: frame_count increments modulo 2^COUNT_W, and frame_done (registered) is high for exactly the next cycle.
- GAP state: out=0, out_valid=0, busy=1. Lasts GAP_CYCLES cycles, then IDLE.
- IDLE state: out=0, out_valid=0, busy=0. IDLE always lasts at least 1 cycle.
- Minimum frame period: 1 + PRE_W + DATA_W + GAP_CYCLES cycles (15 with defaults).
- Outside SHIFT, out is held at 0 (Moore, glitch-free, decoded from registered state and shift register).
- Reset mid-frame: frame is aborted and not counted; frame_count is cleared; all outputs return to reset values on the next edge.
- Reset has priority over a simultaneous handshake: the word is dropped.
- Payload is not escaped: data bits matching PREAMBLE are transmitted unchanged.
- bit_cnt width: clog2(PRE_W+DATA_W+1). gap counter width: clog2(GAP_CYCLES+1), min 1.

Decomposition:
- Package seq_tx_pkg holds:
  - FSM state localparams (IDLE=2'b00, SHIFT=2'b01, GAP=2'b10);
  - default PREAMBLE 4'b1010.
- One natural sub-module: piso_shift_reg, a parallel-load, shift-left register exposing its MSB, with width parameter PRE_W+DATA_W.
- FSM, counters and frame_count stay in seq_frame_tx.

Test Plan:
- Reset, then data_in=8'hA5 with data_valid for 1 cycle:
  - out over the next 12 cycles = 1,0,1,0,1,0,1,0,0,1,0,1;
  - out_is_data low for the first 4 of those cycles, high for the last 8;
  - frame_done high in cycle 13;
  - frame_count=1;
  - data_ready back high at cycle 15.
- data_valid held high with 8'h00 then 8'hFF: accepting edges exactly 15 cycles apart; second frame's data bits are all 1; frame_count=2.
- data_valid asserted during SHIFT and during GAP: no capture, data_ready=0 throughout, the frame in flight is unchanged.
- Reset asserted at the 6th bit of a frame:
  - next cycle out=0, out_valid=0, busy=0, frame_count=0, data_ready=1;
  - no frame_done pulse.
- COUNT_W=2, GAP_CYCLES=0: send 5 frames. frame_count after each = 1,2,3,0,1, and the frame period is 13 cycles.
- Reset and handshake in the same cycle: word is dropped, state stays IDLE, out stays 0.
